// File: rtl/audio_level_meter.sv
// Stereo level meter: strobe sync, saturated |L|/|R| max, fast-attack/slow-decay 8-bit envelope.
// Optional peak hold enabled by defining METER_PEAK_HOLD_EN.
module audio_level_meter #(
    parameter int Width       = 24,
    parameter int DecayDiv    = 480,
    parameter int DecayStep   = 1,
    parameter int HoldSamples = 24000
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Strobe,
    input  logic [Width-1:0] DataL,
    input  logic [Width-1:0] DataR,
    output logic [7:0]       Level,
    output logic [7:0]       PeakLevel,
    output logic             LevelValid,
    output logic             Overrun
);

    localparam int DivW = $clog2(DecayDiv + 1);
    localparam logic signed [Width-1:0] MinVal = {1'b1, {(Width-1){1'b0}}};
    localparam logic signed [Width-1:0] MaxVal = {1'b0, {(Width-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, CAPTURE, COMPUTE, UPDATE} state_t;

    // Saturated magnitude, top 8 bits below the sign so full scale reads 0xFF.
    function automatic logic [7:0] mag8(input logic signed [Width-1:0] x);
        logic signed [Width-1:0] m;
        if (x[Width-1]) m = (x == MinVal) ? MaxVal : -x;
        else            m = x;
        return m[Width-2:Width-9];
    endfunction

    function automatic logic [7:0] decay_floor(input logic [7:0] env, input logic [7:0] cur);
        logic [8:0] diff;
        logic [7:0] dec;
        diff = {1'b0, env} - 9'(DecayStep);
        dec  = diff[8] ? 8'd0 : diff[7:0];
        return (dec > cur) ? dec : cur;
    endfunction

    state_t                   state_q, state_d;
    logic                     s1_q, s2_q, s3_q;
    logic                     edge_w;
    logic signed [Width-1:0]  samp_l_q, samp_r_q;
    logic [7:0]               abs_l_q, abs_r_q;
    logic [7:0]               cur_w;
    logic [7:0]               env_q, env_d;
    logic [DivW-1:0]          cnt_q, cnt_d;
    logic                     valid_q, valid_d;
    logic                     ovr_q, ovr_d;

    assign edge_w = s2_q & ~s3_q;
    assign cur_w  = (abs_l_q >= abs_r_q) ? abs_l_q : abs_r_q;

    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q | (edge_w && (state_q != IDLE));
        case (state_q)
            IDLE:    if (edge_w) state_d = CAPTURE;
            CAPTURE: state_d = COMPUTE;
            COMPUTE: begin
                // Envelope result is registered on entry to UPDATE so it is visible with the pulse.
                state_d = UPDATE;
                valid_d = 1'b1;
                if (cur_w >= env_q) begin
                    env_d = cur_w;
                    cnt_d = '0;
                end else if (cnt_q == DivW'(DecayDiv - 1)) begin
                    cnt_d = '0;
                    env_d = decay_floor(env_q, cur_w);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q <= IDLE;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            env_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            s1_q    <= Strobe;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            env_q   <= env_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Sample datapath carries no reset; it is only consumed under FSM control.
    always_ff @(posedge Clock) begin
        if (state_q == IDLE && edge_w) begin
            samp_l_q <= DataL;
            samp_r_q <= DataR;
        end
        abs_l_q <= mag8(samp_l_q);
        abs_r_q <= mag8(samp_r_q);
    end

`ifdef METER_PEAK_HOLD_EN
    localparam int HoldW = $clog2(HoldSamples + 1);

    logic [7:0]       peak_q, peak_d;
    logic [HoldW-1:0] hold_q, hold_d;

    always_comb begin
        peak_d = peak_q;
        hold_d = hold_q;
        if (state_q == COMPUTE) begin
            if (cur_w >= peak_q) begin
                peak_d = cur_w;
                hold_d = HoldW'(HoldSamples - 1);
            end else if (hold_q != '0) begin
                hold_d = hold_q - 1'b1;
            end else begin
                peak_d = env_d;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            peak_q <= '0;
            hold_q <= '0;
        end else begin
            peak_q <= peak_d;
            hold_q <= hold_d;
        end
    end

    assign PeakLevel = peak_q;
`else
    assign PeakLevel = env_q;
`endif

    assign Level      = env_q;
    assign LevelValid = valid_q;
    assign Overrun    = ovr_q;

endmodule

// File: tb/tb_audio_level_meter.sv
// Scoreboard bench for audio_level_meter: two instances (default decay, and DecayDiv=1/HoldSamples=4).
module tb_audio_level_meter;

    logic        clk = 1'b0;
    logic        Reset, Strobe;
    logic [23:0] DataL, DataR;
    logic [7:0]  lvl0, pk0, lvl1, pk1;
    logic        v0, v1, ov0, ov1;

    always #15 clk = ~clk;

    audio_level_meter u0 (
        .Clock(clk), .Reset(Reset), .Strobe(Strobe), .DataL(DataL), .DataR(DataR),
        .Level(lvl0), .PeakLevel(pk0), .LevelValid(v0), .Overrun(ov0)
    );

    audio_level_meter #(.DecayDiv(1), .HoldSamples(4)) u1 (
        .Clock(clk), .Reset(Reset), .Strobe(Strobe), .DataL(DataL), .DataR(DataR),
        .Level(lvl1), .PeakLevel(pk1), .LevelValid(v1), .Overrun(ov1)
    );

    typedef struct {int lvl; int pk; int ov;} exp_t;
    exp_t q0[$];
    exp_t q1[$];

    int n_cmp = 0, n_fail = 0;
    int cyc = 0;
    int last_start = 0;
    int pulses0 = 0, pulses1 = 0;
    int last_lvl0 = -1, last_lvl1 = -1, last_pk1 = -1, last_ov0 = -1, last_vcyc0 = 0;

    int env[2], cnt[2], pk[2], hld[2];
    int divs[2] = '{480, 1};
    int hs[2]   = '{24000, 4};
    int exp_ovr;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int mag(input logic [23:0] x);
        int v;
        v = x[23] ? (32'h1000000 - int'(x)) : int'(x);
        if (v > 32'h7FFFFF) v = 32'h7FFFFF;
        return v / 32768;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            env[i] = 0; cnt[i] = 0; pk[i] = 0; hld[i] = 0;
        end
        exp_ovr = 0;
    endtask

    task automatic model_apply(input logic [23:0] l, input logic [23:0] r);
        int cur, e;
        exp_t x;
        cur = (mag(l) > mag(r)) ? mag(l) : mag(r);
        for (int i = 0; i < 2; i++) begin
            if (cur >= env[i]) begin
                env[i] = cur; cnt[i] = 0;
            end else if (cnt[i] == divs[i] - 1) begin
                cnt[i] = 0;
                e = env[i] - 1;
                if (e < 0) e = 0;
                if (e < cur) e = cur;
                env[i] = e;
            end else begin
                cnt[i]++;
            end
`ifdef METER_PEAK_HOLD_EN
            if (cur >= pk[i]) begin
                pk[i] = cur; hld[i] = hs[i] - 1;
            end else if (hld[i] > 0) begin
                hld[i]--;
            end else begin
                pk[i] = env[i];
            end
`else
            pk[i] = env[i];
`endif
            x.lvl = env[i]; x.pk = pk[i]; x.ov = exp_ovr;
            if (i == 0) q0.push_back(x);
            else        q1.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (v0) begin
            pulses0++; last_lvl0 = lvl0; last_ov0 = ov0; last_vcyc0 = cyc;
            if (q0.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL u0_unexpected_valid: got pulse level 0x%0h required none", lvl0);
            end else begin
                e = q0.pop_front();
                chk("u0_level", lvl0, e.lvl);
                chk("u0_peak", pk0, e.pk);
                chk("u0_overrun", ov0, e.ov);
            end
        end
        if (v1) begin
            pulses1++; last_lvl1 = lvl1; last_pk1 = pk1;
            if (q1.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL u1_unexpected_valid: got pulse level 0x%0h required none", lvl1);
            end else begin
                e = q1.pop_front();
                chk("u1_level", lvl1, e.lvl);
                chk("u1_peak", pk1, e.pk);
                chk("u1_overrun", ov1, e.ov);
            end
        end
    end

    task automatic send(input logic [23:0] l, input logic [23:0] r, input int hi);
        @(negedge clk);
        DataL = l; DataR = r; Strobe = 1'b1;
        last_start = cyc;
        model_apply(l, r);
        repeat (hi) @(negedge clk);
        Strobe = 1'b0;
        repeat (7) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_level", lvl0, 0);
        chk("rst_peak", pk0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_overrun", ov0, 0);
        Reset = 1'b1;
        model_reset();
    endtask

    int p_save;
    int hold_exp[5] = '{8'hC0, 8'hC0, 8'hC0, 8'hBC, 8'hBB};

    initial begin
        Reset = 1'b0; Strobe = 1'b0; DataL = '0; DataR = '0;
        model_reset();
        do_reset();

        // silence: latency and zero level
        send(24'h000000, 24'h000000, 2);
        chk("latency_edges", last_vcyc0 - last_start, 5);
        chk("silence_level", last_lvl0, 8'h00);
        chk("silence_overrun", last_ov0, 0);

        // immediate attack, -1 on the right is ignored
        send(24'h400000, 24'hFFFFFF, 2);
        chk("attack_level", last_lvl0, 8'h80);

        // decay: one step per 480 samples
        repeat (1919) send(24'h0, 24'h0, 2);
        chk("decay_1919", last_lvl0, 8'h7D);
        send(24'h0, 24'h0, 2);
        chk("decay_1920", last_lvl0, 8'h7C);

        // most negative value saturates
        send(24'h000000, 24'h800000, 2);
        chk("saturate_level", last_lvl0, 8'hFF);

        // two strobes two cycles apart: second dropped, overrun sticky
        p_save = pulses0;
        @(negedge clk);
        DataL = 24'h100000; DataR = 24'h0; Strobe = 1'b1;
        exp_ovr = 1;
        model_apply(24'h100000, 24'h0);
        @(negedge clk); Strobe = 1'b0;
        @(negedge clk); Strobe = 1'b1;
        @(negedge clk); Strobe = 1'b0; DataL = 24'h7FFFFF;
        repeat (10) @(negedge clk);
        chk("overrun_pulses", pulses0 - p_save, 1);
        chk("overrun_set", ov0, 1);
        send(24'h0, 24'h0, 2);
        chk("overrun_sticky", last_ov0, 1);
        do_reset();
        chk("overrun_cleared", ov0, 0);

        // reset while a sample is in flight: no pulse
        p_save = pulses0;
        @(negedge clk); DataL = 24'h7FFFFF; DataR = 24'h0; Strobe = 1'b1;
        @(negedge clk);
        @(negedge clk); Strobe = 1'b0;
        @(negedge clk); Reset = 1'b0;
        repeat (2) @(negedge clk);
        Reset = 1'b1;
        model_reset();
        repeat (10) @(negedge clk);
        chk("midreset_pulses", pulses0 - p_save, 0);
        chk("midreset_level", lvl0, 8'h00);

        // strobe held high: one update only
        p_save = pulses0;
        send(24'h200000, 24'h0, 30);
        chk("held_pulses", pulses0 - p_save, 1);
        chk("held_level", last_lvl0, 8'h40);

        // peak hold / fast decay on the second instance
        do_reset();
        send(24'h600000, 24'h0, 2);
`ifdef METER_PEAK_HOLD_EN
        chk("hold_peak_first", last_pk1, 8'hC0);
`else
        chk("nohold_peak_first", last_pk1, 8'hC0);
`endif
        for (int k = 0; k < 5; k++) begin
            send(24'h0, 24'h0, 2);
`ifdef METER_PEAK_HOLD_EN
            chk($sformatf("hold_peak_%0d", k + 1), last_pk1, hold_exp[k]);
`else
            chk($sformatf("nohold_peak_%0d", k + 1), last_pk1, last_lvl1);
`endif
        end
        chk("hold_level_5", last_lvl1, 8'hBB);

        // floor at zero, never wraps
        repeat (190) send(24'h0, 24'h0, 2);
        chk("floor_level", last_lvl1, 8'h00);
        send(24'h0, 24'h0, 2);
        chk("floor_nowrap", last_lvl1, 8'h00);

        repeat (5) @(negedge clk);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
